// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional feature macro: DMEM_MISALIGN_ERR_EN (see dmem_responder).
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [31:0] OUT1_ADDR_DEF = 32'd2000;
    localparam logic [31:0] OUT2_ADDR_DEF = 32'd2004;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, asynchronous read.
// Contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and two result taps.
// Define DMEM_MISALIGN_ERR_EN to add err_o and reject misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] OUT1_ADDR   = OUT1_ADDR_DEF,
    parameter logic [31:0] OUT2_ADDR   = OUT2_ADDR_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic [WORD_W-1:0] out1_o,
    output logic [WORD_W-1:0] out2_o
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic              err_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_ack;
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] r_out1;
    logic [WORD_W-1:0] r_out2;

    logic              w_idle;
    logic              w_go;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [WORD_W-1:0] w_wdata;
    logic              w_inrange;
    logic              w_mis;
    logic              w_ok;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_ram_rdata;

    // With zero wait states the access completes on the accepting edge,
    // before the request latch holds anything, so read the live inputs.
    assign w_idle  = (r_state == ST_IDLE);
    assign w_we    = w_idle ? we_i    : r_we;
    assign w_addr  = w_idle ? addr_i  : r_addr;
    assign w_wdata = w_idle ? wdata_i : r_wdata;

    assign w_go = (w_idle & req_i & (WAIT_CYCLES == 0))
                | ((r_state == ST_WAIT) & (r_cnt == '0));

    assign w_inrange = (w_addr[31:AW+2] == '0);

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_mis = |w_addr[1:0];
`else
    assign w_mis = 1'b0;
`endif

    assign w_ok     = w_inrange & ~w_mis;
    assign w_mem_we = w_go & w_we & w_ok;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (w_mem_we),
        .addr_i (w_addr[AW+1:2]),
        .wdata_i(w_wdata),
        .rdata_o(w_ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_out1  <= '0;
            r_out2  <= '0;
        end else begin
            r_ack <= w_go;
            if (w_go) begin
                if (!w_we) begin
                    r_rdata <= w_ok ? w_ram_rdata : '0;
                end
                if (w_we && !w_mis && (w_addr == OUT1_ADDR)) begin
                    r_out1 <= w_wdata;
                end
                if (w_we && !w_mis && (w_addr == OUT2_ADDR)) begin
                    r_out2 <= w_wdata;
                end
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_go & w_mis;
        end
    end

    assign err_o = r_err;
`endif

    assign busy_o  = (w_idle & req_i) | (r_state == ST_WAIT);
    assign ack_o   = r_ack;
    assign rdata_o = r_rdata;
    assign out1_o  = r_out1;
    assign out2_o  = r_out2;

endmodule
